// File: rtl/stack_sequencer_pkg.sv
// stack_sequencer_pkg
//   Shared definitions for the CALL/RET stack sequencer: FSM state encoding
//   and the default widths / depth of the return-address stack.
package stack_sequencer_pkg;

  localparam int ADDR_W_DEF  = 10;    // return-address width
  localparam int SP_W_DEF    = 10;    // stack pointer / RAM address width
  localparam int STACK_DEPTH = 1024;  // entries in the external stack RAM

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_POP     = 3'd2,
    S_READ    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

endpackage

// File: rtl/stack_sequencer.sv
// stack_sequencer
//   Turns a single-cycle CALL or RET request from decode into an ordered
//   stack-pointer update plus stack-RAM access, and returns popped addresses
//   to the PC logic.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   call_req, ret_req     requests, sampled only in IDLE (CALL wins a tie)
//   ret_addr_in           address pushed by a CALL
//   busy                  high whenever the FSM is not IDLE
//   done                  one-cycle completion pulse (success or error)
//   pc_out, pc_valid      popped address (held) and its one-cycle strobe
//   overflow_err          CALL refused because the stack is full
//   underflow_err         RET refused because the stack is empty
//   sp, stack_overflow    from the stack pointer (sp = next free slot)
//   push, pop             to the stack pointer, each a one-cycle pulse
//   mem_we, mem_re        stack RAM write / read enables
//   mem_addr, mem_wdata   stack RAM address and write data
//   mem_rdata             stack RAM read data, valid one cycle after mem_re
//   dbg_state             current FSM state encoding
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and the request is high; requests while busy are dropped, and the requester
// re-issues after done. done is the only completion indication.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SP_W   = SP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] ret_addr_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              overflow_err,
  output logic              underflow_err,
  input  logic [SP_W-1:0]   sp,
  input  logic              stack_overflow,
  output logic              push,
  output logic              pop,
  output logic              mem_we,
  output logic              mem_re,
  output logic [SP_W-1:0]   mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;     // address latched with the CALL
  logic                is_ret_q;   // current operation is a RET
  logic                ovf_q;      // latched overflow refusal
  logic                unf_q;      // latched underflow refusal

  // State register and datapath latches. Asynchronous reset returns the FSM
  // to IDLE, which drops every state-decoded strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      is_ret_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      pc_out   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        if (call_req) begin
          addr_q   <= ret_addr_in;
          is_ret_q <= 1'b0;
          ovf_q    <= stack_overflow;
          unf_q    <= 1'b0;
        end else if (ret_req) begin
          is_ret_q <= 1'b1;
          ovf_q    <= 1'b0;
          unf_q    <= (sp == '0);
        end
      end
      if (state == S_CAPTURE) begin
        pc_out <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (call_req) begin
          state_nxt = stack_overflow ? S_ERR : S_WRITE;
        end else if (ret_req) begin
          state_nxt = (sp == '0) ? S_ERR : S_POP;
        end
      end
      S_WRITE:   state_nxt = S_DONE;
      S_POP:     state_nxt = S_READ;
      // sp was decremented by POP, so here it addresses the top entry
      S_READ:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // All strobes decode from the registered state only.
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE) || (state == S_ERR);
  assign pc_valid      = (state == S_DONE) && is_ret_q;
  assign overflow_err  = (state == S_ERR) && ovf_q;
  assign underflow_err = (state == S_ERR) && unf_q;
  assign push          = (state == S_WRITE);
  assign pop           = (state == S_POP);
  assign mem_we        = (state == S_WRITE);
  assign mem_re        = (state == S_READ);
  assign mem_addr      = ((state == S_WRITE) || (state == S_READ)) ? sp : '0;
  assign mem_wdata     = (state == S_WRITE) ? addr_q : '0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  localparam int ADDR_W = 10;
  localparam int SP_W   = 10;

  logic              clk;
  logic              rst_n;
  logic              call_req;
  logic              ret_req;
  logic [ADDR_W-1:0] ret_addr_in;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc_out;
  logic              pc_valid;
  logic              overflow_err;
  logic              underflow_err;
  logic [SP_W-1:0]   sp;
  logic              stack_overflow;
  logic              push;
  logic              pop;
  logic              mem_we;
  logic              mem_re;
  logic [SP_W-1:0]   mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_rdata;
  logic [2:0]        dbg_state;

  // environment: stack pointer and synchronous stack RAM
  logic              sp_load;
  logic [SP_W-1:0]   sp_load_val;
  logic [ADDR_W-1:0] ram [0:STACK_DEPTH-1];

  logic [ADDR_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  stack_sequencer #(.ADDR_W(ADDR_W), .SP_W(SP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .call_req(call_req), .ret_req(ret_req), .ret_addr_in(ret_addr_in),
    .busy(busy), .done(done), .pc_out(pc_out), .pc_valid(pc_valid),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .sp(sp), .stack_overflow(stack_overflow),
    .push(push), .pop(pop), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sp_load)   sp <= sp_load_val;
    else if (push) sp <= sp + 1'b1;
    else if (pop)  sp <= sp - 1'b1;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [ADDR_W-1:0] addr);
    logic [SP_W-1:0] sp0;
    sp0 = sp;
    call_req = 1'b1;
    ret_addr_in = addr;
    tick();
    call_req = 1'b0;
    check("call_push", push, 1);
    check("call_pop", pop, 0);
    check("call_we", mem_we, 1);
    check("call_addr", mem_addr, sp0);
    check("call_wdata", mem_wdata, addr);
    check("call_done_early", done, 0);
    exp_q.push_back(addr);
    tick();
    check("call_done", done, 1);
    check("call_pcv", pc_valid, 0);
    check("call_push_once", push, 0);
    check("call_sp", sp, SP_W'(sp0 + 1'b1));
    tick();
    check("call_idle", busy, 0);
  endtask

  task automatic do_ret();
    logic [SP_W-1:0]   sp0;
    logic [SP_W-1:0]   sp1;
    logic [ADDR_W-1:0] exp_pc;
    sp0 = sp;
    sp1 = sp0 - 1'b1;
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    check("ret_pop", pop, 1);
    check("ret_push", push, 0);
    check("ret_re_early", mem_re, 0);
    tick();
    check("ret_re", mem_re, 1);
    check("ret_pop_once", pop, 0);
    check("ret_raddr", mem_addr, sp1);
    tick();
    check("ret_done_early", done, 0);
    tick();
    exp_pc = exp_q.pop_back();
    check("ret_done", done, 1);
    check("ret_pcv", pc_valid, 1);
    check("ret_pc", pc_out, exp_pc);
    check("ret_sp", sp, sp1);
    tick();
    check("ret_pcv_pulse", pc_valid, 0);
    check("ret_pc_hold", pc_out, exp_pc);
    check("ret_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    call_req = 1'b0;
    ret_req = 1'b0;
    ret_addr_in = '0;
    stack_overflow = 1'b0;
    sp_load = 1'b1;
    sp_load_val = '0;
    tick();
    tick();
    sp_load = 1'b0;
    // reset state
    check("rst_state", dbg_state, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc_out, 0);
    check("rst_push", push, 0);
    check("rst_we", mem_we, 0);
    rst_n = 1'b1;
    tick();

    // first CALL at sp=0
    do_call(10'h155);
    check("ram0", ram[0], 10'h155);
    exp_q.delete();
    sp_load = 1'b1; sp_load_val = '0;
    tick();
    sp_load = 1'b0;

    // LIFO order
    do_call(10'h001);
    do_call(10'h002);
    do_call(10'h003);
    do_ret();
    do_ret();
    do_ret();
    check("lifo_sp", sp, 0);

    // underflow
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    check("unf_done", done, 1);
    check("unf_err", underflow_err, 1);
    check("unf_ovf", overflow_err, 0);
    check("unf_pop", pop, 0);
    check("unf_re", mem_re, 0);
    check("unf_pcv", pc_valid, 0);
    tick();
    check("unf_pulse", underflow_err, 0);
    check("unf_sp", sp, 0);

    // overflow
    stack_overflow = 1'b1;
    call_req = 1'b1;
    ret_addr_in = 10'h0AA;
    tick();
    call_req = 1'b0;
    check("ovf_done", done, 1);
    check("ovf_err", overflow_err, 1);
    check("ovf_unf", underflow_err, 0);
    check("ovf_push", push, 0);
    check("ovf_we", mem_we, 0);
    tick();
    stack_overflow = 1'b0;
    check("ovf_pulse", overflow_err, 0);
    check("ovf_sp", sp, 0);

    // simultaneous CALL and RET at sp=5: CALL wins, RET held while busy is ignored
    sp_load = 1'b1; sp_load_val = 10'd5;
    tick();
    sp_load = 1'b0;
    call_req = 1'b1;
    ret_req = 1'b1;
    ret_addr_in = 10'h3FF;
    tick();
    call_req = 1'b0;
    check("tie_push", push, 1);
    check("tie_pop", pop, 0);
    check("tie_addr", mem_addr, 5);
    exp_q.push_back(10'h3FF);
    tick();
    check("tie_done", done, 1);
    check("tie_pcv", pc_valid, 0);
    check("tie_sp", sp, 6);
    ret_req = 1'b0;
    tick();
    check("tie_idle", busy, 0);
    check("tie_sp_hold", sp, 6);
    check("tie_ram", ram[5], 10'h3FF);

    // reset during RET CAPTURE
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    tick();
    tick();
    check("abort_in_capture", dbg_state, S_CAPTURE);
    rst_n = 1'b0;
    #1;
    check("abort_state", dbg_state, S_IDLE);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pcv", pc_valid, 0);
    check("abort_pc", pc_out, 0);
    void'(exp_q.pop_back());  // slot was popped before the abort
    tick();
    check("abort_pcv_later", pc_valid, 0);
    check("abort_sp", sp, 5);
    rst_n = 1'b1;
    tick();
    check("abort_pcv_after", pc_valid, 0);
    do_call(10'h2AA);
    do_ret();
    check("final_sp", sp, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
